legv8_multicycle_ctrl: RTL

Multi-cycle sequencer for the LEGv8 datapath. It holds the instruction register and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Each state drives the same control signal set as the single-cycle decoder: regwrite, memread, memwrite, mem2reg, alu_op, alusrc, branch/jump. It talks to a shared instruction/data memory through a req/ack handshake, so one memory port serves both fetch and load/store.

---
 rtl/legv8_ctrl_pkg.sv | 46 ++++
 rtl/legv8_opcode_decode.sv | 50 +++++
 rtl/legv8_multicycle_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - states, instruction classes, opcode patterns and ALU codes for the LEGv8 multi-cycle controller
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_MOVK, CLS_LOAD, CLS_STORE, CLS_B, CLS_CBZ, CLS_CBNZ, CLS_ILL
  } iclass_t;

  // 11-bit opcode patterns; x bits are zero in the pattern and cleared by the mask
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_MOVK = 11'b11111111100;

  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_MOVK = 11'b11110010100;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_MOVK  = 4'b1000;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/legv8_opcode_decode.sv
// rtl/legv8_opcode_decode.sv - combinational ir[31:21] classifier producing instruction class, alu_op and alusrc
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_t     iclass,
  output logic [3:0]  alu_op,
  output logic        alusrc
);

  always_comb begin
    iclass = CLS_ILL;
    alu_op = ALU_AND;
    alusrc = 1'b0;
    if (op_match(opcode, OP_AND, MASK_FULL)) begin
      iclass = CLS_R;
      alu_op = ALU_AND;
    end else if (op_match(opcode, OP_ADD, MASK_FULL)) begin
      iclass = CLS_R;
      alu_op = ALU_ADD;
    end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
      iclass = CLS_R;
      alu_op = ALU_ORR;
    end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
      iclass = CLS_R;
      alu_op = ALU_SUB;
    end else if (op_match(opcode, OP_MOVK, MASK_MOVK)) begin
      iclass = CLS_MOVK;
      alu_op = ALU_MOVK;
      alusrc = 1'b1;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      iclass = CLS_LOAD;
      alu_op = ALU_ADD;
      alusrc = 1'b1;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      iclass = CLS_STORE;
      alu_op = ALU_ADD;
      alusrc = 1'b1;
    end else if (op_match(opcode, OP_B, MASK_B)) begin
      iclass = CLS_B;
    end else if (op_match(opcode, OP_CBZ, MASK_CB)) begin
      iclass = CLS_CBZ;
      alu_op = ALU_PASSB;
    end else if (op_match(opcode, OP_CBNZ, MASK_CB)) begin
      iclass = CLS_CBNZ;
      alu_op = ALU_PASSB;
    end
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 multi-cycle sequencer with shared-memory handshake and ack timeout
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP instead of retiring as a NOP.
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        zero,
  output logic [31:0] ir,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        mem2reg,
  output logic        alusrc,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        mem_err,
  output logic        illegal
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end

  localparam logic        TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      st;
  iclass_t     cls_q;
  iclass_t     dec_cls;
  logic [3:0]  dec_alu_op;
  logic        dec_alusrc;
  logic [15:0] wait_cnt;
  logic        pc_write_q;
  logic        pc_src_q;
  logic        ack_ok;
  logic        timeout;
  logic        br_taken;

  legv8_opcode_decode u_dec (
    .opcode (ir[31:21]),
    .iclass (dec_cls),
    .alu_op (dec_alu_op),
    .alusrc (dec_alusrc)
  );

  // an ack only counts while a request is outstanding, so acks arriving after reset are dropped
  assign ack_ok   = mem_req & mem_ack;
  assign timeout  = TO_EN & mem_req & ~mem_ack & (wait_cnt == TO_LAST);
  assign br_taken = (st == S_EXEC) &&
                    ((cls_q == CLS_CBZ && zero) || (cls_q == CLS_CBNZ && !zero));

  // zero and the store ack only exist in the cycle that consumes them
  assign pc_write = pc_write_q | ((st == S_MEM) && (cls_q == CLS_STORE) && ack_ok);
  assign pc_src   = {1'b0, pc_src_q | br_taken};
  assign state    = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= S_FETCH;
      cls_q      <= CLS_R;
      ir         <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      pc_write_q <= 1'b0;
      pc_src_q   <= 1'b0;
      regwrite   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      mem2reg    <= 1'b0;
      alusrc     <= 1'b0;
      alu_op     <= ALU_AND;
      mem_err    <= 1'b0;
      illegal    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      pc_write_q <= 1'b0;
      pc_src_q   <= 1'b0;
      regwrite   <= 1'b0;
      mem2reg    <= 1'b0;
      alusrc     <= 1'b0;
      alu_op     <= ALU_AND;
      case (st)
        S_FETCH: begin
          if (ack_ok) begin
            ir       <= mem_rdata;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            st       <= S_DECODE;
          end else if (timeout) begin
            mem_err  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            mem_req <= 1'b1;
            if (mem_req) wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          cls_q  <= dec_cls;
          alu_op <= dec_alu_op;
          alusrc <= dec_alusrc;
          st     <= S_EXEC;
          case (dec_cls)
            CLS_B: begin
              pc_write_q <= 1'b1;
              pc_src_q   <= 1'b1;
            end
            CLS_CBZ, CLS_CBNZ: pc_write_q <= 1'b1;
            CLS_ILL: begin
`ifdef ILLEGAL_TRAP_EN
              st      <= S_TRAP;
              illegal <= 1'b1;
`else
              pc_write_q <= 1'b1;
`endif
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            CLS_R, CLS_MOVK: begin
              st         <= S_WB;
              regwrite   <= 1'b1;
              pc_write_q <= 1'b1;
            end
            CLS_LOAD: begin
              st      <= S_MEM;
              mem_req <= 1'b1;
              memread <= 1'b1;
            end
            CLS_STORE: begin
              st       <= S_MEM;
              mem_req  <= 1'b1;
              mem_we   <= 1'b1;
              memwrite <= 1'b1;
            end
            default: begin
              st      <= S_FETCH;
              mem_req <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (ack_ok || timeout) begin
            mem_we   <= 1'b0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            wait_cnt <= '0;
            // mem_req stays high when heading to FETCH: the next request starts at once
            if (timeout) begin
              mem_err <= 1'b1;
              st      <= S_FETCH;
            end else if (cls_q == CLS_LOAD) begin
              st         <= S_WB;
              mem_req    <= 1'b0;
              regwrite   <= 1'b1;
              mem2reg    <= 1'b1;
              pc_write_q <= 1'b1;
            end else begin
              st <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_WB: begin
          st      <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_TRAP: mem_req <= 1'b0;
        default: st <= S_FETCH;
      endcase
    end
  end

endmodule
